// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed common-anode hex display scanner with frame-synchronous update.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_display #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] DataIn,
  input  logic        DataValid,
  output logic [7:0]  nDigit,
  output logic [6:0]  nSegment,
  output logic        FrameStart
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] LIT_END  = 16'(SCAN_DIV - BLANK_CYCLES);

  logic [31:0] pend_data;
  logic        pend_valid;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic [15:0] div;
  logic [2:0]  idx;

  logic        slot_end;
  logic        frame_end;
  logic [7:0]  lz_blank;
  logic [3:0]  nibble;
  logic        on;
  logic [7:0]  digit_next;
  logic [6:0]  seg_next;

  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_end  = (div == DIV_LAST);
  assign frame_end = slot_end && (idx == 3'd7);

  // Blanking is derived from the displayed word only, so it cannot change mid-frame.
`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign lz_blank[0] = 1'b0;
  for (genvar gi = 1; gi < 8; gi++) begin : g_lz
    assign lz_blank[gi] = ~|disp_data[31:4*gi];
  end
`else
  assign lz_blank = 8'h00;
`endif

  always_comb begin
    nibble     = disp_data[{idx, 2'b00} +: 4];
    on         = disp_valid && (div < LIT_END) && !lz_blank[idx];
    digit_next = 8'hFF;
    seg_next   = 7'h7F;
    if (on) begin
      digit_next = ~(8'b1 << idx);
      seg_next   = ~hex7seg(nibble);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_data  <= 32'h0;
      pend_valid <= 1'b0;
      disp_data  <= 32'h0;
      disp_valid <= 1'b0;
      div        <= 16'h0;
      idx        <= 3'd0;
      FrameStart <= 1'b0;
      nDigit     <= 8'hFF;
      nSegment   <= 7'h7F;
    end else begin
      pend_valid <= DataValid;
      if (DataValid) pend_data <= DataIn;
      if (slot_end) begin
        div <= 16'h0;
        idx <= idx + 3'd1;
      end else begin
        div <= div + 16'd1;
      end
      // The display registers take the value pending before this edge, not the one arriving on it.
      if (frame_end) begin
        disp_data  <= pend_data;
        disp_valid <= pend_valid;
      end
      FrameStart <= frame_end;
      nDigit     <= digit_next;
      nSegment   <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboarded bench for seg_scan_display (SCAN_DIV=8, BLANK_CYCLES=2): one expected frame
// image is queued per driven word and compared sample-by-sample when the DUT plays that frame.
module tb_seg_scan_display;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 8 * SD;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] DataIn;
  logic        DataValid;
  logic [7:0]  nDigit;
  logic [6:0]  nSegment;
  logic        FrameStart;

  always #5 HCLK = ~HCLK;

  seg_scan_display #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .DataIn(DataIn), .DataValid(DataValid),
    .nDigit(nDigit), .nSegment(nSegment), .FrameStart(FrameStart));

  typedef struct { logic valid; logic [31:0] data; } frame_t;
  typedef struct { logic valid; logic [31:0] data; int t; } step_t;

  frame_t sb_q[$];
  frame_t cur;
  bit     have_cur = 1'b0;
  bit     seen_fs  = 1'b0;
  int     pos = 0;
  int     cyc = 0;
  int     err_cnt = 0;
  int     chk_cnt = 0;

  // t = cycle within the frame (0 = FrameStart cycle) at which the new inputs are driven
  step_t steps [10] = '{
    '{1'b0, 32'h0000_0000, 10}, '{1'b0, 32'h0000_0000, 10}, '{1'b0, 32'h0000_0000, 10},
    '{1'b1, 32'h0123_ABCD, 10}, '{1'b1, 32'hFFFF_FFFF, 30}, '{1'b0, 32'hFFFF_FFFF, 20},
    '{1'b1, 32'h0000_0050, 5},  '{1'b1, 32'h89AB_CDEF, 62}, '{1'b1, 32'h1357_2468, 63},
    '{1'b1, 32'h1357_2468, 10}};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit lzb(input int slot, input logic [31:0] data);
    return LZ_EN && (slot != 0) && ((data >> (4 * slot)) == 32'h0);
  endfunction

  // Monitor: sample at negedge; sample n after FrameStart belongs to frame position n-1.
  initial begin
    int slot, d;
    bit lit;
    logic [3:0] nib;
    logic [7:0] one_hot, e_dig;
    logic [6:0] e_seg;
    forever begin
      @(negedge HCLK);
      cyc++;
      if (have_cur && pos < FRAME) begin
        slot    = pos / SD;
        d       = pos % SD;
        lit     = cur.valid && (d < SD - BC) && !lzb(slot, cur.data);
        nib     = 4'((cur.data >> (4 * slot)) & 32'hF);
        one_hot = 8'b1 << slot;
        e_dig   = lit ? ~one_hot : 8'hFF;
        e_seg   = lit ? ~GLYPH[nib] : 7'h7F;
        check("ndigit", {24'h0, nDigit}, {24'h0, e_dig});
        check("nsegment", {25'h0, nSegment}, {25'h0, e_seg});
        pos++;
      end
      if (FrameStart) begin
        if (seen_fs) check("fs_period", cyc, FRAME);
        seen_fs = 1'b1;
        cyc = 0;
        if (sb_q.size() == 0) begin
          check("sb_empty", 0, 1);
          have_cur = 1'b0;
        end else begin
          cur = sb_q.pop_front();
          have_cur = 1'b1;
          $display("frame start t=%0t: expect valid=%0b data=%h", $time, cur.valid, cur.data);
        end
        pos = 0;
      end
    end
  end

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(posedge HCLK);
      #1;
      n++;
    end while (!FrameStart && n < 3 * FRAME);
    if (!FrameStart) check("fs_timeout", 0, 1);
  endtask

  initial begin
    int n;
    HRESET = 1'b1;
    DataValid = 1'b0;
    DataIn = 32'h0;
    #1;
    check("rst_ndigit", {24'h0, nDigit}, 32'hFF);
    check("rst_nsegment", {25'h0, nSegment}, 32'h7F);
    check("rst_framestart", {31'h0, FrameStart}, 0);
    repeat (3) @(posedge HCLK);
    #1;
    sb_q.push_back(frame_t'{1'b0, 32'h0});
    HRESET = 1'b0;

    for (int i = 0; i < 10; i++) begin
      wait_fs(n);
      repeat (steps[i].t) @(posedge HCLK);
      #1;
      if (steps[i].t >= FRAME - 1) begin
        // Driven on the boundary cycle: the next frame still shows what was pending.
        sb_q.push_back(frame_t'{DataValid, DataIn});
      end else begin
        sb_q.push_back(frame_t'{steps[i].valid, steps[i].data});
      end
      DataValid = steps[i].valid;
      DataIn    = steps[i].data;
      $display("drive step %0d: valid=%0b data=%h at frame cycle %0d", i, steps[i].valid,
               steps[i].data, steps[i].t);
    end

    // Asynchronous reset in the lit part of slot 5
    wait_fs(n);
    repeat (5 * SD + 2) @(posedge HCLK);
    #3;
    HRESET = 1'b1;
    have_cur = 1'b0;
    seen_fs = 1'b0;
    sb_q.delete();
    DataValid = 1'b0;
    #1;
    check("async_rst_ndigit", {24'h0, nDigit}, 32'hFF);
    check("async_rst_nsegment", {25'h0, nSegment}, 32'h7F);
    check("async_rst_framestart", {31'h0, FrameStart}, 0);
    $display("reset asserted mid slot 5 at t=%0t", $time);
    repeat (3) @(posedge HCLK);
    #1;
    sb_q.push_back(frame_t'{1'b0, 32'h0});
    HRESET = 1'b0;
    wait_fs(n);
    check("fs_after_reset", n, FRAME);
    $display("first FrameStart %0d cycles after reset release", n);
    sb_q.push_back(frame_t'{1'b0, 32'h0});
    repeat (FRAME + 6) @(posedge HCLK);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
